// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// default header tag nibble.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly above ptr,
// wrapping to the lowest asserted request when none lies above it.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [N_REQ-1:0] upper;

    always_comb begin
        upper  = '0;
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            upper[i] = req[i] && (i > int'(ptr));
        end
        // The wrapped search result is overridden by any hit above the pointer.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) gnt_id = ID_W'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (upper[i]) gnt_id = ID_W'(i);
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single UART TX; holds a grant for a
// whole packet and prefixes each packet with a source-identifying header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ          = 4,
    parameter int         BITS_N         = 8,
    parameter bit         HEADER_EN      = 1'b1,
    parameter logic [3:0] HDR_TAG        = HDR_TAG_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*BITS_N-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [BITS_N-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      abort
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                full;
    logic [CNT_W-1:0]    idle_cnt;
    logic                load_hdr;
    logic                load_pay;
    logic                pkt_end;
    logic [BITS_N-1:0]   pay_byte;
    logic [BITS_N-1:0]   hdr_byte;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign pay_byte = req_data[int'(grant_id)*BITS_N +: BITS_N];
    assign hdr_byte = BITS_N'({HDR_TAG, 4'(grant_id)});
    assign tx_valid = full;
    assign pkt_end  = (load_pay && req_last[grant_id]) || abort;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Loads are only issued while the holding register is empty, so a load can
    // never coincide with a drain and tx_data stays put for the cycle after it.
    always_comb begin
        state_nxt = state;
        load_hdr  = 1'b0;
        load_pay  = 1'b0;
        req_ready = '0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = HEADER_EN ? HEADER : PAYLOAD;
            end
            HEADER: begin
                if (!full) begin
                    load_hdr  = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!full && req_valid[grant_id]) begin
                    load_pay            = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    if (req_last[grant_id]) state_nxt = IDLE;
                end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= ID_W'(N_REQ - 1);
            grant_id <= '0;
            busy     <= 1'b0;
            full     <= 1'b0;
            tx_data  <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant_id <= pick_id;
                busy     <= 1'b1;
            end
            if (pkt_end) begin
                rr_ptr <= grant_id;
                busy   <= 1'b0;
            end
            if (load_hdr) begin
                full    <= 1'b1;
                tx_data <= hdr_byte;
            end else if (load_pay) begin
                full    <= 1'b1;
                tx_data <= pay_byte;
            end else if (full && tx_ready) begin
                full <= 1'b0;
            end
            if (state == PAYLOAD && !load_pay && !abort) idle_cnt <= idle_cnt + CNT_W'(1);
            else                                         idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one header-enabled and one header-less
// instance, driven by a byte-queue requester model and a UART sink model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic        tx_ready;

    logic [3:0]  a_req_ready, b_req_ready;
    logic [7:0]  a_tx_data,   b_tx_data;
    logic        a_tx_valid,  b_tx_valid;
    logic [1:0]  a_grant,     b_grant;
    logic        a_busy,      b_busy;
    logic        a_abort,     b_abort;

    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(4), .BITS_N(8), .HEADER_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst_a), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(a_req_ready), .tx_data(a_tx_data),
        .tx_valid(a_tx_valid), .tx_ready(tx_ready), .grant_id(a_grant),
        .busy(a_busy), .abort(a_abort)
    );

    uart_tx_arbiter #(
        .N_REQ(4), .BITS_N(8), .HEADER_EN(1'b0), .HDR_TAG(4'hA), .TIMEOUT_CYCLES(16)
    ) dut_nh (
        .clk(clk), .rst(rst_b), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(b_req_ready), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_ready(tx_ready), .grant_id(b_grant),
        .busy(b_busy), .abort(b_abort)
    );

    int tests_run = 0;
    int fails = 0;

    logic [7:0] qd [4][32];
    logic       ql [4][32];
    int         wr [4];
    int         rd [4];

    logic [7:0] log_b [64];
    int         log_n;
    int         cyc = 0;
    logic       pend;
    logic       hs_now;
    logic [7:0] hs_byte;
    bit         slow = 1'b0;
    int         stab_n, stab_bad, bad_ready, abort_n, abort_cyc;
    int         load_cyc [4];

    logic [3:0] s_ready;
    logic [7:0] s_data;
    logic       s_valid, s_busy, s_abort;
    logic [1:0] s_grant;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = qd[i][rd[i]];
                req_last[i]        = ql[i][rd[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_ready = slow ? !hs_now : 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        s_ready = sel ? b_req_ready : a_req_ready;
        s_data  = sel ? b_tx_data   : a_tx_data;
        s_valid = sel ? b_tx_valid  : a_tx_valid;
        s_grant = sel ? b_grant     : a_grant;
        s_busy  = sel ? b_busy      : a_busy;
        s_abort = sel ? b_abort     : a_abort;
        hs_now  = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                stab_n++;
                if (s_data !== hs_byte) stab_bad++;
                pend = 1'b0;
            end
            if (s_valid && tx_ready) begin
                hs_byte = s_data;
                pend    = 1'b1;
                hs_now  = 1'b1;
                if (log_n < 64) begin
                    log_b[log_n] = s_data;
                    log_n++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (s_ready[i]) begin
                    load_cyc[i] = cyc;
                    if (rd[i] < wr[i]) rd[i]++;
                end
            end
            if (s_ready != 4'b0 && (s_ready != (4'b1 << s_grant) || !s_busy)) bad_ready++;
            if (s_abort) begin
                abort_n++;
                abort_cyc = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic l);
        qd[i][wr[i]] = b;
        ql[i][wr[i]] = l;
        wr[i]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            rd[i] = 0;
            load_cyc[i] = -1;
        end
        for (int k = 0; k < 64; k++) log_b[k] = 8'h00;
        log_n = 0; pend = 1'b0; hs_now = 1'b0; stab_n = 0; stab_bad = 0;
        bad_ready = 0; abort_n = 0; abort_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        drive();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        drive();
        tick();
        tick();
        tests_run++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %0b expected 0", s_valid); end
        tests_run++; if (s_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h expected 00", s_data); end
        tests_run++; if (s_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", s_ready); end
        tests_run++; if (s_grant !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", s_grant); end
        tests_run++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", s_busy); end
        tests_run++; if (s_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %0b expected 0", s_abort); end
        rst = 1'b0;
    endtask

    task automatic test_reset_priority();
        logic [7:0] exp [5];
        exp = '{8'hA1, 8'h11, 8'h12, 8'hA3, 8'h33};
        do_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1); push(3, 8'h33, 1'b1);
        drive();
        tick();
        tests_run++; if (s_busy !== 1'b0) begin fails++; $display("FAIL prio_busy_t0: got %0b expected 0", s_busy); end
        tick();
        tests_run++; if (s_busy !== 1'b1) begin fails++; $display("FAIL prio_busy_t1: got %0b expected 1", s_busy); end
        tests_run++; if (s_grant !== 2'd1) begin fails++; $display("FAIL prio_grant_t1: got %0d expected 1", s_grant); end
        tests_run++; if (s_valid !== 1'b0) begin fails++; $display("FAIL prio_tx_valid_t1: got %0b expected 0", s_valid); end
        tick();
        tests_run++; if (s_valid !== 1'b1) begin fails++; $display("FAIL prio_tx_valid_t2: got %0b expected 1", s_valid); end
        tests_run++; if (s_data !== 8'hA1) begin fails++; $display("FAIL prio_header_t2: got %02h expected a1", s_data); end
        repeat (30) tick();
        tests_run++; if (log_n !== 5) begin fails++; $display("FAIL prio_count: got %0d expected 5", log_n); end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL prio_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [15];
        exp = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA2, 8'h21, 8'h22,
                8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
        drive();
        repeat (60) tick();
        tests_run++; if (log_n !== 15) begin fails++; $display("FAIL rr_count: got %0d expected 15", log_n); end
        for (int k = 0; k < 15; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL rr_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
        tests_run++; if (bad_ready !== 0) begin fails++; $display("FAIL rr_ready_onehot: got %0d violations expected 0", bad_ready); end
    endtask

    task automatic test_data_stability();
        logic [7:0] exp [4];
        exp = '{8'hA2, 8'h55, 8'hAA, 8'hFF};
        do_reset();
        slow = 1'b1;
        push(2, 8'h55, 1'b0); push(2, 8'hAA, 1'b0); push(2, 8'hFF, 1'b1);
        drive();
        repeat (40) tick();
        slow = 1'b0;
        tests_run++; if (log_n !== 4) begin fails++; $display("FAIL stab_count: got %0d expected 4", log_n); end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL stab_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
        tests_run++; if (stab_n !== 4) begin fails++; $display("FAIL stab_samples: got %0d expected 4", stab_n); end
        tests_run++; if (stab_bad !== 0) begin fails++; $display("FAIL stab_hold: got %0d changed bytes expected 0", stab_bad); end
    endtask

    task automatic test_timeout();
        logic [7:0] exp [4];
        exp = '{8'hA0, 8'h01, 8'hA1, 8'h11};
        do_reset();
        push(0, 8'h01, 1'b0); push(1, 8'h11, 1'b1);
        drive();
        repeat (50) tick();
        tests_run++; if (abort_n !== 1) begin fails++; $display("FAIL to_abort_count: got %0d expected 1", abort_n); end
        tests_run++; if (abort_cyc - load_cyc[0] !== 16) begin fails++; $display("FAIL to_abort_delay: got %0d expected 16", abort_cyc - load_cyc[0]); end
        tests_run++; if (log_n !== 4) begin fails++; $display("FAIL to_count: got %0d expected 4", log_n); end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL to_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
        tests_run++; if (bad_ready !== 0) begin fails++; $display("FAIL to_ready_onehot: got %0d violations expected 0", bad_ready); end
    endtask

    task automatic test_header_disabled();
        logic [7:0] exp [3];
        exp = '{8'h20, 8'h21, 8'h30};
        sel = 1'b1;
        do_reset();
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1); push(3, 8'h30, 1'b1);
        drive();
        repeat (30) tick();
        tests_run++; if (log_n !== 3) begin fails++; $display("FAIL nh_count: got %0d expected 3", log_n); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL nh_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
        tests_run++; if (bad_ready !== 0) begin fails++; $display("FAIL nh_ready_onehot: got %0d violations expected 0", bad_ready); end
        tests_run++; if (s_grant !== 2'd3) begin fails++; $display("FAIL nh_last_grant: got %0d expected 3", s_grant); end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp [4];
        exp = '{8'hA0, 8'h07, 8'hA2, 8'h22};
        do_reset();
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        drive();
        repeat (4) tick();
        rst = 1'b1;
        drive();
        tick();
        tests_run++; if (s_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %0b expected 1", s_busy); end
        rst = 1'b0;
        log_n = 0;
        for (int k = 0; k < 64; k++) log_b[k] = 8'h00;
        push(0, 8'h07, 1'b1);
        drive();
        tick();
        tests_run++; if (s_valid !== 1'b0) begin fails++; $display("FAIL mid_tx_valid_after: got %0b expected 0", s_valid); end
        tests_run++; if (s_busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after: got %0b expected 0", s_busy); end
        repeat (30) tick();
        tests_run++; if (log_n !== 5) begin fails++; $display("FAIL mid_count: got %0d expected 5", log_n); end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (log_b[k] !== exp[k]) begin fails++; $display("FAIL mid_byte%0d: got %02h expected %02h", k, log_b[k], exp[k]); end
        end
        tests_run++; if (abort_n !== 0) begin fails++; $display("FAIL mid_no_abort: got %0d expected 0", abort_n); end
    endtask

    initial begin
        clear_all();
        drive();
        test_reset();
        test_reset_priority();
        test_round_robin();
        test_data_stability();
        test_timeout();
        test_header_disabled();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
